// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, shifter operand (Val2) generation, ALU with NZCV
// status register, branch target adder and the EXE/MEM pipeline register.
module exe_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_EN_EXE,
   input  logic        MEM_R_EN_EXE,
   input  logic        MEM_W_EN_EXE,
   input  logic        S_EXE,
   input  logic        B_EXE,
   input  logic [3:0]  EXE_CMD_EXE,
   input  logic        imm_EXE,
   input  logic [11:0] shift_operand_EXE,
   input  logic [31:0] val_Rn_EXE,
   input  logic [31:0] val_Rm_EXE,
   input  logic [3:0]  dest_EXE,
   input  logic [31:0] pc_EXE,
   input  logic [23:0] signed_imm_24_EXE,
   input  logic [1:0]  sel_src1,
   input  logic [1:0]  sel_src2,
   input  logic [31:0] wb_value_WB,
   input  logic        freeze,
   output logic        WB_EN_MEM,
   output logic        MEM_R_EN_MEM,
   output logic        MEM_W_EN_MEM,
   output logic [31:0] alu_res_MEM,
   output logic [31:0] rm_val_MEM,
   output logic [3:0]  dest_MEM,
   output logic [3:0]  status,
   output logic [31:0] branch_addr,
   output logic        B_taken
);

   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] val2;
   logic [31:0] alu_res;
   logic [32:0] sum;
   logic        c_nx;
   logic        v_nx;
   logic [63:0] imm_rot;
   logic [63:0] rm_rot;
   logic [4:0]  sh_amt;

   always_comb begin
      case (sel_src1)
         2'b01:   src1 = alu_res_MEM;
         2'b10:   src1 = wb_value_WB;
         default: src1 = val_Rn_EXE;
      endcase
      case (sel_src2)
         2'b01:   src2 = alu_res_MEM;
         2'b10:   src2 = wb_value_WB;
         default: src2 = val_Rm_EXE;
      endcase
   end

   // Rotations use a doubled word so that a zero amount needs no special case.
   always_comb begin
      sh_amt  = shift_operand_EXE[11:7];
      imm_rot = {32'b0, 24'b0, shift_operand_EXE[7:0]} >> {shift_operand_EXE[11:8], 1'b0};
      imm_rot = imm_rot | ({32'b0, 24'b0, shift_operand_EXE[7:0]} << (6'd32 - {1'b0, shift_operand_EXE[11:8], 1'b0}));
      rm_rot  = {src2, src2} >> sh_amt;
      if (imm_EXE) begin
         val2 = imm_rot[31:0] | imm_rot[63:32];
      end else if (MEM_R_EN_EXE || MEM_W_EN_EXE) begin
         val2 = {20'b0, shift_operand_EXE};
      end else begin
         case (shift_operand_EXE[6:5])
            2'b00:   val2 = src2 << sh_amt;
            2'b01:   val2 = src2 >> sh_amt;
            2'b10:   val2 = $unsigned($signed(src2) >>> sh_amt);
            default: val2 = rm_rot[31:0];
         endcase
      end
   end

   // Subtraction is Rn + ~Val2 + carry-in so that bit 32 is directly NOT borrow.
   always_comb begin
      sum     = '0;
      alu_res = '0;
      c_nx    = status[1];
      v_nx    = status[0];
      case (EXE_CMD_EXE)
         4'b0001: alu_res = val2;
         4'b1001: alu_res = ~val2;
         4'b0010, 4'b0011: begin
            sum     = {1'b0, src1} + {1'b0, val2} + {32'b0, (EXE_CMD_EXE[0] & status[1])};
            alu_res = sum[31:0];
            c_nx    = sum[32];
            v_nx    = (src1[31] == val2[31]) && (alu_res[31] != src1[31]);
         end
         4'b0100, 4'b0101: begin
            sum     = {1'b0, src1} + {1'b0, ~val2} + {32'b0, (EXE_CMD_EXE[0] ? status[1] : 1'b1)};
            alu_res = sum[31:0];
            c_nx    = sum[32];
            v_nx    = (src1[31] != val2[31]) && (alu_res[31] != src1[31]);
         end
         4'b0110: alu_res = src1 & val2;
         4'b0111: alu_res = src1 | val2;
         4'b1000: alu_res = src1 ^ val2;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status <= '0;
      end else if (S_EXE && !freeze) begin
         status <= {alu_res[31], (alu_res == 32'd0), c_nx, v_nx};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         WB_EN_MEM    <= 1'b0;
         MEM_R_EN_MEM <= 1'b0;
         MEM_W_EN_MEM <= 1'b0;
         alu_res_MEM  <= '0;
         rm_val_MEM   <= '0;
         dest_MEM     <= '0;
      end else if (!freeze) begin
         WB_EN_MEM    <= WB_EN_EXE;
         MEM_R_EN_MEM <= MEM_R_EN_EXE;
         MEM_W_EN_MEM <= MEM_W_EN_EXE;
         alu_res_MEM  <= alu_res;
         rm_val_MEM   <= src2;
         dest_MEM     <= dest_EXE;
      end
   end

   assign branch_addr = pc_EXE + {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};
   assign B_taken     = B_EXE;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push hand-computed EXE/MEM results,
// a monitor pops one per clock and compares; reset and branch paths are checked directly.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE;
   logic [3:0]  EXE_CMD_EXE;
   logic        imm_EXE;
   logic [11:0] shift_operand_EXE;
   logic [31:0] val_Rn_EXE, val_Rm_EXE;
   logic [3:0]  dest_EXE;
   logic [31:0] pc_EXE;
   logic [23:0] signed_imm_24_EXE;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] wb_value_WB;
   logic        freeze;
   logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
   logic [31:0] alu_res_MEM, rm_val_MEM;
   logic [3:0]  dest_MEM;
   logic [3:0]  status;
   logic [31:0] branch_addr;
   logic        B_taken;

   exe_stage dut (
      .clk(clk), .rst(rst),
      .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
      .S_EXE(S_EXE), .B_EXE(B_EXE), .EXE_CMD_EXE(EXE_CMD_EXE), .imm_EXE(imm_EXE),
      .shift_operand_EXE(shift_operand_EXE), .val_Rn_EXE(val_Rn_EXE), .val_Rm_EXE(val_Rm_EXE),
      .dest_EXE(dest_EXE), .pc_EXE(pc_EXE), .signed_imm_24_EXE(signed_imm_24_EXE),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .wb_value_WB(wb_value_WB), .freeze(freeze),
      .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
      .alu_res_MEM(alu_res_MEM), .rm_val_MEM(rm_val_MEM), .dest_MEM(dest_MEM),
      .status(status), .branch_addr(branch_addr), .B_taken(B_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb, mr, mw, s, b, imm, frz;
      logic [3:0]  cmd, dest;
      logic [11:0] so;
      logic [31:0] rn, rm, wbv;
      logic [1:0]  s1, s2;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] alu, rm;
      logic [3:0]  dest, st;
      logic [2:0]  ctrl;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_id = 0;

   task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, id, act, want);
      end
   endtask

   function automatic vec_t op(input logic [3:0] cmd, input logic s, input logic imm,
                               input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                               input logic [3:0] dest);
      vec_t v;
      v.wb = 1'b1; v.mr = 1'b0; v.mw = 1'b0; v.b = 1'b0; v.frz = 1'b0;
      v.s = s; v.imm = imm; v.cmd = cmd; v.so = so; v.rn = rn; v.rm = rm; v.dest = dest;
      v.wbv = 32'h0; v.s1 = 2'b00; v.s2 = 2'b00;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      WB_EN_EXE = v.wb; MEM_R_EN_EXE = v.mr; MEM_W_EN_EXE = v.mw; S_EXE = v.s; B_EXE = v.b;
      EXE_CMD_EXE = v.cmd; imm_EXE = v.imm; shift_operand_EXE = v.so;
      val_Rn_EXE = v.rn; val_Rm_EXE = v.rm; dest_EXE = v.dest;
      sel_src1 = v.s1; sel_src2 = v.s2; wb_value_WB = v.wbv; freeze = v.frz;
   endtask

   task automatic step(input vec_t v, input logic [31:0] ealu, input logic [31:0] erm,
                       input logic [3:0] edest, input logic [2:0] ectrl, input logic [3:0] est);
      exp_t e;
      @(negedge clk);
      drive(v);
      step_id++;
      e.id = step_id; e.alu = ealu; e.rm = erm; e.dest = edest; e.ctrl = ectrl; e.st = est;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("alu_res_MEM", e.id, alu_res_MEM, e.alu);
         check("rm_val_MEM", e.id, rm_val_MEM, e.rm);
         check("dest_MEM", e.id, {28'b0, dest_MEM}, {28'b0, e.dest});
         check("ctrl_MEM", e.id, {29'b0, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM}, {29'b0, e.ctrl});
         check("status", e.id, {28'b0, status}, {28'b0, e.st});
      end
   end

   task automatic check_all_zero(input string nm);
      check({nm, "_alu"}, 0, alu_res_MEM, 32'h0);
      check({nm, "_rm"}, 0, rm_val_MEM, 32'h0);
      check({nm, "_dest"}, 0, {28'b0, dest_MEM}, 32'h0);
      check({nm, "_ctrl"}, 0, {29'b0, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM}, 32'h0);
      check({nm, "_status"}, 0, {28'b0, status}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      v = op(4'b0000, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 4'h0);
      v.wb = 1'b0;
      drive(v);
      pc_EXE = 32'h0; signed_imm_24_EXE = 24'h0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      @(negedge clk);
      rst = 1'b1;

      step(op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h55, 4'd3), 32'h80000000, 32'h55, 4'd3, 3'b100, 4'b1001);
      step(op(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5, 32'h0, 4'd4), 32'h0, 32'h0, 4'd4, 3'b100, 4'b0110);
      step(op(4'b0011, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0, 4'd4), 32'd3, 32'h0, 4'd4, 3'b100, 4'b0000);
      step(op(4'b0001, 1'b0, 1'b1, 12'h2FF, 32'h0, 32'h0, 4'd2), 32'hF000000F, 32'h0, 4'd2, 3'b100, 4'b0000);
      step(op(4'b0010, 1'b0, 1'b1, 12'h006, 32'd4, 32'h0, 4'd5), 32'd10, 32'h0, 4'd5, 3'b100, 4'b0000);
      v = op(4'b0010, 1'b0, 1'b1, 12'h001, 32'h999, 32'h1234, 4'd5);
      v.s1 = 2'b01; v.s2 = 2'b10; v.wbv = 32'd7;
      step(v, 32'd11, 32'd7, 4'd5, 3'b100, 4'b0000);
      step(op(4'b0001, 1'b0, 1'b0, 12'h0C0, 32'h0, 32'h80000001, 4'd7), 32'hC0000000, 32'h80000001, 4'd7, 3'b100, 4'b0000);
      step(op(4'b0001, 1'b0, 1'b0, 12'h260, 32'h0, 32'h12345678, 4'd7), 32'h81234567, 32'h12345678, 4'd7, 3'b100, 4'b0000);
      step(op(4'b0100, 1'b1, 1'b1, 12'h003, 32'd5, 32'h0, 4'd8), 32'd2, 32'h0, 4'd8, 3'b100, 4'b0010);
      step(op(4'b1001, 1'b1, 1'b0, 12'h000, 32'h0, 32'hDEADBEEF, 4'd8), 32'h21524110, 32'hDEADBEEF, 4'd8, 3'b100, 4'b0010);
      v = op(4'b0010, 1'b0, 1'b0, 12'hABC, 32'h1000, 32'h0, 4'd9);
      v.mr = 1'b1;
      step(v, 32'h1ABC, 32'h0, 4'd9, 3'b110, 4'b0010);
      step(op(4'b0001, 1'b0, 1'b0, 12'hFA0, 32'h0, 32'h80000000, 4'd9), 32'h1, 32'h80000000, 4'd9, 3'b100, 4'b0010);
      step(op(4'b0110, 1'b0, 1'b1, 12'h0FF, 32'hF0F0, 32'h0, 4'd1), 32'hF0, 32'h0, 4'd1, 3'b100, 4'b0010);
      step(op(4'b0111, 1'b0, 1'b1, 12'h0FF, 32'hF00, 32'h0, 4'd1), 32'hFFF, 32'h0, 4'd1, 3'b100, 4'b0010);
      step(op(4'b1000, 1'b0, 1'b1, 12'h0FF, 32'hF0, 32'h0, 4'd1), 32'h0F, 32'h0, 4'd1, 3'b100, 4'b0010);
      step(op(4'b0000, 1'b1, 1'b1, 12'h0FF, 32'h123, 32'h0, 4'd1), 32'h0, 32'h0, 4'd1, 3'b100, 4'b0110);
      step(op(4'b0101, 1'b1, 1'b1, 12'h003, 32'd10, 32'h0, 4'd6), 32'd7, 32'h0, 4'd6, 3'b100, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         v = op(4'b0100, 1'b1, 1'b1, 12'h005, 32'd5 + 32'(i), 32'hA0 + 32'(i), 4'(10 + i));
         v.frz = 1'b1; v.wb = 1'b0; v.mw = 1'b1;
         step(v, 32'd7, 32'h0, 4'd6, 3'b100, 4'b0010);
      end
      step(op(4'b0010, 1'b1, 1'b1, 12'h002, 32'd2, 32'h77, 4'd12), 32'd4, 32'h77, 4'd12, 3'b100, 4'b0000);
      step(op(4'b0010, 1'b1, 1'b1, 12'h001, 32'hFFFFFFFF, 32'h0, 4'd13), 32'h0, 32'h0, 4'd13, 3'b100, 4'b0110);
      step(op(4'b0100, 1'b1, 1'b1, 12'h001, 32'h80000000, 32'h0, 4'd14), 32'h7FFFFFFF, 32'h0, 4'd14, 3'b100, 4'b0011);
      @(posedge clk);
      #2;
      check("queue_drained", 0, exp_q.size(), 0);

      // Asynchronous reset between edges, with freeze held through and after it.
      @(negedge clk);
      freeze = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("frozen_after_reset");
      step(op(4'b0010, 1'b1, 1'b1, 12'h004, 32'd3, 32'h9, 4'd2), 32'd7, 32'h9, 4'd2, 3'b100, 4'b0000);
      @(posedge clk);
      #2;

      pc_EXE = 32'h100; signed_imm_24_EXE = 24'hFFFFFF; B_EXE = 1'b1;
      #1;
      check("branch_back", 0, branch_addr, 32'h000000FC);
      check("b_taken_hi", 0, {31'b0, B_taken}, 32'd1);
      pc_EXE = 32'h1000; signed_imm_24_EXE = 24'h000010; B_EXE = 1'b0;
      #1;
      check("branch_fwd", 0, branch_addr, 32'h00001040);
      check("b_taken_lo", 0, {31'b0, B_taken}, 32'd0);
      pc_EXE = 32'h4; signed_imm_24_EXE = 24'h800000;
      #1;
      check("branch_wrap", 0, branch_addr, 32'hFE000004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, register index at 4 bits.
REQ-002 clk  in  1  stage clock, rising-edge active.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE  in  1 each  control bits from ID/EXE register.
REQ-005 EXE_CMD_EXE  in  4  ALU command.
REQ-006 imm_EXE  in  1  shifter operand is immediate.
REQ-007 shift_operand_EXE  in  12  shifter operand field.
REQ-008 val_Rn_EXE, val_Rm_EXE  in  32 each  register-file operands.
REQ-009 dest_EXE  in  4  destination register.
REQ-010 pc_EXE  in  32  PC+4 of the instruction.
REQ-011 signed_imm_24_EXE  in  24  branch offset.
REQ-012 sel_src1, sel_src2  in  2 each  forwarding select for Rn / Rm.
REQ-013 wb_value_WB  in  32  write-back value for forwarding.
REQ-014 freeze  in  1  hold stage (driven by ~ready of memory stage).
REQ-015 WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  out  1 each  registered controls.
REQ-016 alu_res_MEM, rm_val_MEM  out  32 each  registered ALU result / store data.
REQ-017 dest_MEM  out  4  registered destination.
REQ-018 status  out  4  NZCV register {N,Z,C,V}.
REQ-019 branch_addr  out  32  combinational branch target; B_taken  out  1  equals B_EXE.

Function
REQ-020 Operand select: 00 = ID value, 01 = alu_res_MEM (own registered output), 10 = wb_value_WB, 11 = ID value; src1 feeds Rn, src2 feeds Rm.
REQ-021 Val2, imm_EXE=1: zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8].
REQ-022 Val2, imm_EXE=0 and (MEM_R_EN_EXE or MEM_W_EN_EXE): zero-extended shift_operand[11:0].
REQ-023 Val2 otherwise: forwarded Rm shifted by shift_operand[11:7]; type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR; amount 0 returns Rm unchanged.
REQ-024 Commands: 0001 MOV Val2; 1001 MVN ~Val2; 0010 ADD Rn+Val2; 0011 ADC Rn+Val2+C; 0100 SUB Rn-Val2; 0101 SBC Rn-Val2-(1-C); 0110 AND; 0111 ORR; 1000 EOR; others result 0, flags N/Z only.
REQ-025 Arithmetic in 33 bits; C = bit 32 for add, NOT borrow for subtract; V = signed overflow; logic/move ops leave C, V unchanged.
REQ-026 N = result[31]; Z = (result == 0).
REQ-027 Status register updates at rising edge only when S_EXE=1 and freeze=0; else holds.
REQ-028 EXE/MEM register captures controls, ALU result, forwarded Rm, dest at rising edge when freeze=0; holds all fields when freeze=1.
REQ-029 Latency: one cycle from EXE inputs to *_MEM outputs; forwarding path combinational.
REQ-030 branch_addr = pc_EXE + (sign_extend(signed_imm_24_EXE) << 2), modulo 2^32.
REQ-031 Simultaneous freeze and S_EXE: freeze wins, no flag update.
REQ-032 32-bit wrap-around of all sums is silent, reflected only in C/V.

Reset
REQ-033 rst low asynchronously clears all *_MEM outputs and status to 0, regardless of clk or freeze.
REQ-034 rst deasserted: first capture on next rising edge with freeze=0.
REQ-035 Reset mid-freeze: registers clear; freeze state after reset needs no restoration.

Verification
REQ-036 ADD Rn=0x7FFFFFFF, imm 1, S=1 -> alu_res_MEM=0x80000000, status=1001 next cycle.
REQ-037 SUB Rn=5, Val2=5, S=1 -> result 0, status=0110; then ADC 1+1 -> 3.
REQ-038 imm_EXE=1, shift_operand=0x2FF -> Val2=0xF000000F; MOV result 0xF000000F.
REQ-039 freeze=1 for 3 cycles with changing inputs and S=1 -> outputs and status unchanged; resume captures current inputs.
REQ-040 sel_src1=01 after ADD producing 10, next ADD imm 1 -> 11; sel_src2=10 with wb_value_WB=7 -> rm_val_MEM=7.
REQ-041 rst pulsed low between edges with outputs nonzero -> all outputs 0 immediately; branch pc_EXE=0x100, imm24=0xFFFFFF -> branch_addr=0xFC.
